// File: rtl/barrido_display_pkg.sv
// Shared constants, FSM state type and blanking helper for the display scanner.
// Optional build macro LZB_EN enables leading-zero blanking in the top level.
package display_pkg;

  localparam int N_DIG = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_t;

  // Leading-zero test for the digit d of a 4-nibble BCD word
  function automatic logic lzb_blank(
    input logic [15:0] w,
    input logic [1:0]  d
  );
    logic r;
    r = 1'b0;
    unique case (d)
      2'd3:    r = (w[15:12] == 4'd0);
      2'd2:    r = (w[15:8]  == 8'd0);
      2'd1:    r = (w[15:4]  == 12'd0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/barrido_display_if.sv
// Scan/data inputs and display pin outputs of the 4-digit scanner.
// master drives scan count and data, slave drives the display pins.
interface barrido_display_if;

  logic [1:0]  cuenta;
  logic        load;
  logic [15:0] datos;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        digito_ok;

  modport master (
    output cuenta, load, datos,
    input  an_n, seg_n, digito_ok
  );

  modport slave (
    input  cuenta, load, datos,
    output an_n, seg_n, digito_ok
  );

endinterface

// File: rtl/barrido_display_bcd_a_7seg.sv
// BCD nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes 10..15 render as a lone middle dash.
module bcd_a_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_n
);

  // Segment lookup
  always_comb begin
    o_seg_n = SEG_DASH;
    unique case (i_bcd)
      4'd0:    o_seg_n = 7'b1000000;
      4'd1:    o_seg_n = 7'b1111001;
      4'd2:    o_seg_n = 7'b0100100;
      4'd3:    o_seg_n = 7'b0110000;
      4'd4:    o_seg_n = 7'b0011001;
      4'd5:    o_seg_n = 7'b0010010;
      4'd6:    o_seg_n = 7'b0000010;
      4'd7:    o_seg_n = 7'b1111000;
      4'd8:    o_seg_n = 7'b0000000;
      4'd9:    o_seg_n = 7'b0010000;
      default: o_seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/barrido_display.sv
// 4-digit common-anode scanner: double-buffered BCD word, blank-on-change FSM.
// Define LZB_EN to blank leading zeros (digit0 is always shown).
module barrido_display
  import display_pkg::*;
#(
  parameter int BLANK_CYC = 4,
  parameter int DATA_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  barrido_display_if.slave bus
);

  localparam int CW = $clog2(BLANK_CYC + 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);

  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_active;
  logic [1:0]        r_sel_q;
  logic [CW-1:0]     r_bcnt;
  state_t            r_state;
  logic [3:0]        r_an_n;
  logic [6:0]        r_seg_n;
  logic              r_ok;

  logic              w_chg;
  logic              w_wrap;
  logic [3:0]        w_nib;
  logic [6:0]        w_dec;
  logic [6:0]        w_seg;

  assign w_chg  = (bus.cuenta != r_sel_q);
  assign w_wrap = (r_sel_q == 2'd3) && (bus.cuenta == 2'd0);
  assign w_nib  = r_active[4*r_sel_q +: 4];

  bcd_a_7seg u_dec (
    .i_bcd   (w_nib),
    .o_seg_n (w_dec)
  );

`ifdef LZB_EN
  assign w_seg = lzb_blank(r_active, r_sel_q) ? SEG_BLANK : w_dec;
`else
  assign w_seg = w_dec;
`endif

  // Shadow capture on load; frame-wrap commit into the displayed word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (bus.load)
        r_shadow <= bus.datos;
      if (w_wrap)
        r_active <= r_shadow;
    end
  end

  // Digit-change detect, blank interval count and registered pin drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_q <= 2'd0;
      r_bcnt  <= '0;
      r_state <= ST_BLANK;
      r_an_n  <= 4'b1111;
      r_seg_n <= SEG_BLANK;
      r_ok    <= 1'b0;
    end else if (w_chg) begin
      r_sel_q <= bus.cuenta;
      r_bcnt  <= '0;
      r_state <= ST_BLANK;
      r_an_n  <= 4'b1111;
      r_seg_n <= SEG_BLANK;
      r_ok    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_BLANK: begin
          r_bcnt <= r_bcnt + CW'(1);
          if (r_bcnt == BLK_LAST) begin
            r_state <= ST_ON;
            r_an_n  <= ~(4'b0001 << r_sel_q);
            r_seg_n <= w_seg;
            r_ok    <= 1'b1;
          end
        end
        ST_ON:   r_state <= ST_ON;
        default: r_state <= ST_BLANK;
      endcase
    end
  end

  assign bus.an_n      = r_an_n;
  assign bus.seg_n     = r_seg_n;
  assign bus.digito_ok = r_ok;

endmodule

// File: tb/tb_barrido_display.sv
// Directed bench for barrido_display: reset, blanking, commit, decode, LZB.
// Build with +define+LZB_EN to exercise leading-zero blanking.
module tb_barrido_display;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  barrido_display_if bus ();

  barrido_display #(
    .BLANK_CYC (4),
    .DATA_W    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] SDSH = 7'b0111111;
  localparam logic [6:0] SOFF = 7'h7F;

`ifdef LZB_EN
  localparam logic [6:0] SLZ = SOFF;
`else
  localparam logic [6:0] SLZ = S0;
`endif

  task automatic check(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] want
  );
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dark(input string tag);
    check({tag, ".an"},  16'(bus.an_n),      16'hF);
    check({tag, ".seg"}, 16'(bus.seg_n),     16'h7F);
    check({tag, ".ok"},  16'(bus.digito_ok), 16'h0);
  endtask

  task automatic lit(
    input string      tag,
    input logic [3:0] an,
    input logic [6:0] seg
  );
    check({tag, ".an"},  16'(bus.an_n),      16'(an));
    check({tag, ".seg"}, 16'(bus.seg_n),     16'(seg));
    check({tag, ".ok"},  16'(bus.digito_ok), 16'h1);
  endtask

  task automatic go(input logic [1:0] c);
    bus.cuenta = c;
    tick(1);
  endtask

  task automatic ld(input logic [15:0] d);
    bus.load  = 1'b1;
    bus.datos = d;
    tick(1);
    bus.load  = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    bus.cuenta = 2'd0;
    bus.load   = 1'b0;
    bus.datos  = 16'h0000;
    #12;
    dark("rst");
    reset = 1'b1;

    tick(3);
    dark("rel_dark");
    tick(1);
    lit("rel_on", 4'b1110, S0);

    #3 reset = 1'b0;
    #1 dark("async_rst");
    #1 reset = 1'b1;
    tick(4);
    lit("rerel_on", 4'b1110, S0);

    ld(16'h1234);
    go(2'd3);
    tick(4);
    lit("pre_commit", 4'b0111, S0);
    go(2'd0);
    dark("wrap_dark0");
    tick(3);
    dark("wrap_dark3");
    tick(1);
    lit("d0_4", 4'b1110, S4);
    go(2'd1);
    tick(4);
    lit("d1_3", 4'b1101, S3);

    ld(16'h5678);
    lit("hold_load", 4'b1101, S3);
    go(2'd2);
    tick(4);
    lit("d2_2", 4'b1011, S2);
    go(2'd3);
    tick(4);
    lit("d3_1", 4'b0111, S1);

    bus.cuenta = 2'd0;
    ld(16'h00B0);
    tick(4);
    lit("wrapld_d0_8", 4'b1110, S8);
    go(2'd1);
    tick(4);
    lit("wrapld_d1_7", 4'b1101, S7);

    go(2'd2);
    tick(1);
    go(2'd3);
    tick(3);
    dark("restart_dark");
    tick(1);
    lit("restart_d3_5", 4'b0111, S5);

    go(2'd0);
    tick(4);
    lit("f3_d0_0", 4'b1110, S0);
    go(2'd1);
    tick(4);
    lit("dash_d1", 4'b1101, SDSH);

    ld(16'h0040);
    go(2'd3);
    tick(4);
    go(2'd0);
    tick(4);
    lit("lz_d0", 4'b1110, S0);
    go(2'd1);
    tick(4);
    lit("lz_d1", 4'b1101, S4);
    go(2'd2);
    tick(4);
    lit("lz_d2", 4'b1011, SLZ);
    go(2'd3);
    tick(4);
    lit("lz_d3", 4'b0111, SLZ);

    go(2'd1);
    ld(16'h9999);
    tick(3);
    lit("nowrap_d1", 4'b1101, S4);
    go(2'd3);
    tick(4);
    lit("nowrap_d3", 4'b0111, SLZ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
